// File: rtl/coincidence_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coincidence_buffer_arbiter
// Purpose  : Round-robin read scheduler that drains NUM_BUFFERS same-clock
//            coincidence buffers (show-ahead off, one-cycle read latency)
//            into a single valid/ready output stream, one word at a time.
// Ports    :
//   clk           - single clock shared with the buffers
//   rst           - asynchronous reset, active low
//   enable        - high: new grants allowed; low: finish current word, idle
//   buf_empty     - per-buffer empty flag (bit i = buffer i)
//   buf_odata     - concatenated buffer read data (slice i = buffer i)
//   buf_odata_req - one-hot-or-zero read request toward the buffers
//   out_data      - captured word
//   out_src       - index of the buffer that supplied out_data
//   out_valid     - out_data/out_src valid
//   out_ready     - consumer accepts the word when out_valid & out_ready
//   busy          - FSM is not idle
//   word_count    - words delivered since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module coincidence_buffer_arbiter #(
  parameter int NUM_BUFFERS = 4,
  parameter int DATA_WIDTH  = 1024,
  parameter int SRC_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_BUFFERS-1:0]            buf_empty,
  input  logic [NUM_BUFFERS*DATA_WIDTH-1:0] buf_odata,
  output logic [NUM_BUFFERS-1:0]            buf_odata_req,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [SRC_WIDTH-1:0]              out_src,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [31:0]                       word_count
);

  localparam logic [SRC_WIDTH:0]   C_NB         = (SRC_WIDTH+1)'(NUM_BUFFERS);
  localparam logic [SRC_WIDTH-1:0] C_LAST_RESET = SRC_WIDTH'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [SRC_WIDTH-1:0]    r_grant;
  logic [SRC_WIDTH-1:0]    r_last_grant;
  logic [SRC_WIDTH-1:0]    w_pick;
  logic [SRC_WIDTH:0]      w_cand;
  logic                    w_found;
  logic                    w_arb;
  logic                    w_hs;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  // Rotating priority search: start at last_grant+1 and wrap. The candidate
  // index carries one extra bit so the wrap can be done with a single
  // conditional subtract, which also works for non-power-of-two counts.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_BUFFERS; k++) begin
      w_cand = {1'b0, r_last_grant} + (SRC_WIDTH+1)'(k);
      if (w_cand >= C_NB) begin
        w_cand = w_cand - C_NB;
      end
      if (!w_found && !buf_empty[w_cand[SRC_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[SRC_WIDTH-1:0];
      end
    end
  end

  assign w_hs = (r_state == HOLD) && out_ready;

  always_comb begin
    w_next = r_state;
    w_arb  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_next = REQ;
          w_arb  = 1'b1;
        end
      end
      REQ:  w_next = CAPT;
      CAPT: w_next = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (enable && w_found) begin
            w_next = REQ;
            w_arb  = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Read data of the granted buffer; valid during CAPT (one cycle after REQ).
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (r_grant == SRC_WIDTH'(i)) begin
        w_sel_data = buf_odata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= C_LAST_RESET;
      out_data     <= '0;
      out_src      <= '0;
      word_count   <= '0;
    end else begin
      r_state <= w_next;
      // last_grant follows the newly registered grant so the next search
      // starts just past the buffer being served now.
      if (w_arb) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      if (r_state == CAPT) begin
        out_data <= w_sel_data;
        out_src  <= r_grant;
      end
      if (w_hs) begin
        word_count <= word_count + 32'd1;
      end
    end
  end

  // Request depends only on state and grant: exactly one pulse per grant,
  // so a buffer that was non-empty at arbitration can never underflow.
  generate
    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_req
      assign buf_odata_req[i] = (r_state == REQ) && (r_grant == SRC_WIDTH'(i));
    end
  endgenerate

  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/coincidence_buffer_arbiter.md
# coincidence_buffer_arbiter

Round-robin read scheduler that drains `NUM_BUFFERS` coincidence buffers into one shared output stream. It sits downstream of the per-channel coincidence buffers (same-clock dcfifos, show-ahead off, one-cycle read latency, underflow checking on). It owns every buffer's `odata_req`, never reads an empty buffer, and presents one word at a time on a valid/ready interface toward the packet/transfer logic.

## Interface
Parameters:
- `NUM_BUFFERS`, 4: number of coincidence buffers served; 2..16.
- `DATA_WIDTH`, 1024: width of one coincidence word; equals buffer width.
- `SRC_WIDTH`, 2: width of source index; must equal ceil(log2(NUM_BUFFERS)), minimum 1.

Ports:
- `clk`  in  1  single clock for block and buffers.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high: new grants allowed; low: finish in-flight word, then idle.
- `buf_empty`  in  NUM_BUFFERS  per-buffer empty flag; bit i = buffer i.
- `buf_odata`  in  NUM_BUFFERS*DATA_WIDTH  buffer read data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `buf_odata_req`  out  NUM_BUFFERS  one-hot-or-zero read request to buffer i.
- `out_data`  out  DATA_WIDTH  captured word.
- `out_src`  out  SRC_WIDTH  index of the buffer that supplied `out_data`.
- `out_valid`  out  1  `out_data`/`out_src` valid.
- `out_ready`  in  1  consumer accepts word when `out_valid & out_ready`.
- `busy`  out  1  state != IDLE.
- `word_count`  out  32  words delivered since reset; wraps 0xFFFFFFFF -> 0.

## Operation
- FSM states: IDLE, REQ, CAPT, HOLD. Reset state: IDLE.
- Arbitration (evaluated in IDLE, and in HOLD on handshake): candidate set = buffers with `buf_empty[i]==0`. Pick the first candidate searching upward from `last_grant+1` modulo NUM_BUFFERS. Register the result into `grant`; `last_grant <= grant`. Reset value of `last_grant` is NUM_BUFFERS-1, so buffer 0 has first priority.
- IDLE -> REQ when `enable` is high and the candidate set is non-empty; otherwise stay in IDLE.
- REQ: `buf_odata_req[grant]` = 1 for exactly this one cycle, all other bits 0. Next state is CAPT.
- CAPT: `out_data <= buf_odata[grant slice]` and `out_src <= grant`. Next state is HOLD.
- HOLD: `out_valid`=1, and data is held stable until the handshake.
  - On handshake with `enable` high and a candidate present: re-arbitrate and go to REQ.
  - On handshake otherwise: go to IDLE.
  - No handshake: stay in HOLD.
- `word_count` increments by 1 on every handshake.
- `buf_odata_req` is combinational from state/grant only (state==REQ), and never depends on `out_ready`.
- `enable` falling while in REQ/CAPT/HOLD: the current word completes normally, and no further grant is issued.
- `buf_empty` of the granted buffer changing after grant is ignored. A buffer is granted only if it was non-empty in the arbitration cycle. A single request per grant guarantees no underflow.

## Timing
- Reset values: `buf_odata_req`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `busy`=0, `word_count`=0, `grant`=0, `last_grant`=NUM_BUFFERS-1.
- Reset asserted mid-operation: FSM returns to IDLE immediately. Any word in flight is discarded, and `word_count` is cleared.
- Latency when idle with `out_ready` held high:
  - cycle 0: arbitrate (IDLE, candidate seen).
  - cycle 1: REQ.
  - cycle 2: CAPT (buffer q valid).
  - cycle 3: `out_valid`=1 and handshake.
- Sustained throughput with back-to-back handshakes: one word per 3 cycles (HOLD -> REQ -> CAPT -> HOLD).
- `out_valid` never drops without a handshake. `out_data`/`out_src` do not change while `out_valid`=1.
- At most one `buf_odata_req` bit is high in any cycle, and never two consecutive cycles for the same grant.

## Test plan
- Reset release with all `buf_empty`=1 and `enable`=1 -> 100 cycles: `buf_odata_req`=0, `out_valid`=0, `busy`=0, `word_count`=0.
- Only buffer 2 non-empty holding 0xA5..A5, `out_ready`=1 -> `buf_odata_req`=4'b0100 at cycle 1, `out_valid` at cycle 3 with `out_data`=0xA5..A5, `out_src`=2, `word_count`=1.
- All 4 buffers non-empty, each with 3 words, `out_ready`=1 -> `out_src` sequence is 0,1,2,3 repeated 3 times, words spaced 3 cycles apart, `word_count`=12, no read while a buffer is empty.
- `out_ready` held 0 for 20 cycles after `out_valid` -> data and `out_src` remain stable and no further `buf_odata_req` is issued; ready=1 -> one handshake and `word_count` +1.
- `enable` dropped during CAPT with 2 buffers non-empty -> the current word is delivered, then IDLE with `busy`=0 and no new request until `enable`=1.
- `rst` asserted in HOLD -> `out_valid`=0 and `word_count`=0 asynchronously. After release, arbitration restarts at buffer 0.
